// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: control-bundle layout,
// forward-select codes, counter width and the forwarding priority function.
package pipe_hazard_ctrl_pkg;

    // The field order fixes the bit positions: reg_write is bit 7, alu_op is [1:0].
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    typedef logic [REG_W-1:0] reg_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef struct packed {
        ctrl_bundle_t ctrl;
        reg_t         rs;
        reg_t         rt;
        reg_t         rd;
    } e_stage_t;

    typedef struct packed {
        ctrl_bundle_t ctrl;
        reg_t         dest;
    } mw_stage_t;

    // Memory stage holds the younger result, so it wins over writeback.
    function automatic fwd_e fwd_sel(input reg_t src, input mw_stage_t m, input mw_stage_t w);
        if (src == '0)
            return FWD_RF;
        if (m.ctrl.reg_write && (m.dest == src))
            return FWD_M;
        if (w.ctrl.reg_write && (w.dest == src))
            return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side inputs and stage/hazard outputs of the pipeline hazard controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [CTRL_W-1:0] ctrl_d;
    logic [REG_W-1:0]  rs_d;
    logic [REG_W-1:0]  rt_d;
    logic [REG_W-1:0]  rd_d;
    logic              zero_e;
    logic              hold;

    logic [CTRL_W-1:0] ctrl_e;
    logic [CTRL_W-1:0] ctrl_m;
    logic [CTRL_W-1:0] ctrl_w;
    logic [REG_W-1:0]  write_reg_e;
    logic [REG_W-1:0]  write_reg_m;
    logic [REG_W-1:0]  write_reg_w;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              pc_src_e;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output ctrl_d, rs_d, rt_d, rd_d, zero_e, hold,
        input  ctrl_e, ctrl_m, ctrl_w, write_reg_e, write_reg_m, write_reg_w,
        input  stall_f, stall_d, flush_d, pc_src_e, forward_a_e, forward_b_e,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  ctrl_d, rs_d, rt_d, rd_d, zero_e, hold,
        output ctrl_e, ctrl_m, ctrl_w, write_reg_e, write_reg_m, write_reg_w,
        output stall_f, stall_d, flush_d, pc_src_e, forward_a_e, forward_b_e,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_reg.sv
// Pipeline stage register: load on enable, synchronous bubble clear, async reset.
module pipe_ctrl_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_q <= '0;
        else if (en_i)
            data_q <= clr_i ? '0 : d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: E/M/W control registers, load-use stall,
// taken-branch flush, operand forwarding, external hold and event counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    e_stage_t         e_d, e_q;
    mw_stage_t        m_d, m_q, w_q;
    reg_t             write_reg_e;
    logic             lwstall, pc_src, advance, e_bubble;
    logic             stall_apply, flush_apply;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    assign e_d         = {bus.ctrl_d, bus.rs_d, bus.rt_d, bus.rd_d};
    assign write_reg_e = e_q.ctrl.reg_dst ? e_q.rd : e_q.rt;
    assign m_d         = {e_q.ctrl, write_reg_e};

    assign pc_src  = e_q.ctrl.branch & bus.zero_e;
    assign lwstall = e_q.ctrl.mem_to_reg & e_q.ctrl.reg_write & (write_reg_e != '0)
                   & ((write_reg_e == bus.rs_d) | (write_reg_e == bus.rt_d));

    // Hold freezes every register; a taken branch masks the load-use stall.
    assign advance     = ~bus.hold;
    assign e_bubble    = lwstall | pc_src;
    assign stall_apply = advance & lwstall & ~pc_src;
    assign flush_apply = advance & pc_src;

    pipe_ctrl_reg #(.W($bits(e_stage_t))) u_reg_e (
        .clk   (clk),
        .reset (reset),
        .en_i  (advance),
        .clr_i (e_bubble),
        .d_i   (e_d),
        .q_o   (e_q)
    );

    pipe_ctrl_reg #(.W($bits(mw_stage_t))) u_reg_m (
        .clk   (clk),
        .reset (reset),
        .en_i  (advance),
        .clr_i (1'b0),
        .d_i   (m_d),
        .q_o   (m_q)
    );

    pipe_ctrl_reg #(.W($bits(mw_stage_t))) u_reg_w (
        .clk   (clk),
        .reset (reset),
        .en_i  (advance),
        .clr_i (1'b0),
        .d_i   (m_q),
        .q_o   (w_q)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_apply && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_apply && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ctrl_e      = e_q.ctrl;
    assign bus.ctrl_m      = m_q.ctrl;
    assign bus.ctrl_w      = w_q.ctrl;
    assign bus.write_reg_e = write_reg_e;
    assign bus.write_reg_m = m_q.dest;
    assign bus.write_reg_w = w_q.dest;

    // hold is an external input, so mask it while reset is asserted.
    assign bus.stall_f     = ~reset & (bus.hold | stall_apply);
    assign bus.stall_d     = ~reset & (bus.hold | stall_apply);
    assign bus.flush_d     = flush_apply;
    assign bus.pc_src_e    = pc_src;
    assign bus.forward_a_e = fwd_sel(e_q.rs, m_q, w_q);
    assign bus.forward_b_e = fwd_sel(e_q.rt, m_q, w_q);
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 (rising edge); reset in 1 (asynchronous, active-high).
REQ-002 SHALL have ports: ctrl_d in 8 ({RegWrite,MemtoReg,MemWrite,Branch,ALUSrc,RegDst,ALUOp[1:0]} from main decoder); rs_d, rt_d, rd_d in 5 each (Decode fields).
REQ-003 SHALL have ports: zero_e in 1 (ALU zero, Execute); hold in 1 (external memory wait, freezes pipeline).
REQ-004 SHALL have ports: ctrl_e, ctrl_m, ctrl_w out 8 (stage control bundles); write_reg_e, write_reg_m, write_reg_w out 5.
REQ-005 SHALL have ports: stall_f, stall_d, flush_d, pc_src_e out 1; forward_a_e, forward_b_e out 2 (00 regfile, 10 from M, 01 from W).
REQ-006 SHALL have ports: stall_cnt, flush_cnt out 16 (performance counters).

Function
REQ-007 SHALL register Decode->E, E->M, M->W: ctrl, rs, rt, rd (E only), dest on each clk edge unless frozen.
REQ-008 SHALL compute write_reg_e = RegDst_e ? rd_e : rt_e; write_reg_m/w SHALL be registered copies.
REQ-009 SHALL drive pc_src_e = Branch_e & zero_e, combinationally.
REQ-010 SHALL detect load-use: lwstall = MemtoReg_e & RegWrite_e & write_reg_e!=0 & (write_reg_e==rs_d | write_reg_e==rt_d).
REQ-011 On lwstall and not pc_src_e: stall_f=stall_d=1, E register loads bubble (ctrl 0), M/W advance normally.
REQ-012 On pc_src_e: flush_d=1, E register loads bubble next edge; lwstall ignored that cycle (branch priority).
REQ-013 forward_a_e SHALL be 10 if RegWrite_m & write_reg_m!=0 & write_reg_m==rs_e; else 01 if RegWrite_w & write_reg_w!=0 & write_reg_w==rs_e; else 00. forward_b_e identical using rt_e.
REQ-014 When hold=1: all stage registers and counters SHALL keep value; stall_f=stall_d=1; flush_d=0; hold overrides lwstall and pc_src_e effects.
REQ-015 stall_cnt SHALL increment once per cycle with lwstall applied (REQ-011); flush_cnt once per cycle with pc_src_e applied; both saturate at 16'hFFFF.
REQ-016 Register 0 SHALL never trigger stall or forwarding.
REQ-017 Latency: control bundle reaches ctrl_e 1, ctrl_m 2, ctrl_w 3 edges after capture, absent stall/flush/hold.

Reset
REQ-018 reset=1 SHALL asynchronously clear all stage registers (ctrl 0, regs 0), both counters; outputs then: forwards 00, stall/flush/pc_src 0.
REQ-019 Reset asserted mid-stall or mid-hold SHALL abort it; first edge after release captures ctrl_d normally.

Structure
REQ-020 Shared package/header SHALL define the ctrl bundle bit positions, forward select codes (FWD_RF, FWD_M, FWD_W) and counter width.
REQ-021 One sub-module pipe_ctrl_reg (parameterised width, enable, synchronous bubble clear, async reset) SHALL implement each stage register.

Verification
REQ-022 lw (ctrl_d 8'hC8, rt_d 5) then add rs_d=5: 1 cycle stall_f=stall_d=1, ctrl_e=0 next edge, stall_cnt=1, then forward_a_e=10 when the add sits in E with lw in M... (lw data via W: forward_a_e=01).
REQ-023 Back-to-back R-type (ctrl 8'h86) writing rd 8, next reading rs 8: forward_a_e=10, no stall; one instruction gap: 01.
REQ-024 beq (ctrl 8'h11) with zero_e=1: pc_src_e=1, flush_d=1, next ctrl_e=0, flush_cnt=1; zero_e=0: no flush.
REQ-025 Branch taken in same cycle as lwstall condition: flush only, stall_cnt unchanged.
REQ-026 hold=1 for 3 cycles mid-sequence: ctrl_e/m/w, counters unchanged; resume sequence identical to no-hold run.
REQ-027 Write to register 0 followed by read of rs 0: forward 00, no stall; reset pulse mid-stall clears all outputs immediately.
